// File: rtl/rfid_clkgen_pkg.sv
// rfid_clkgen_pkg: shared FSM states and configuration defaults for the BLF clock generator
package rfid_clkgen_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
  localparam int MIN_DIV  = 2;
  localparam int DEF_INT  = 2;
  localparam int DEF_FRAC = 0;
  localparam int DEF_AUX  = 0;
endpackage

// File: rtl/rfid_frac_accum.sv
// rfid_frac_accum: dual-modulus period selector; the carry of the fractional accumulator stretches a period by one
module rfid_frac_accum
  import rfid_clkgen_pkg::*;
#(
  parameter int INT_W  = 10,
  parameter int FRAC_W = 4
) (
  input  logic              base_clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              clear_i,
  input  logic [INT_W-1:0]  div_int_i,
  input  logic [FRAC_W-1:0] div_frac_i,
  output logic [INT_W:0]    per_o,
  output logic [INT_W:0]    half_o
);
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W:0]   sum;
  logic [INT_W-1:0]  int_eff;
  always_comb begin
    sum     = {1'b0, acc_q} + {1'b0, div_frac_i};
    int_eff = (div_int_i < INT_W'(MIN_DIV)) ? INT_W'(MIN_DIV) : div_int_i;
    per_o   = {1'b0, int_eff} + {{INT_W{1'b0}}, sum[FRAC_W]};
    half_o  = per_o >> 1;
    acc_d   = clear_i ? '0 : start_i ? sum[FRAC_W-1:0] : acc_q;
  end
  always_ff @(posedge base_clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else acc_q <= acc_d;
  end
endmodule

// File: rtl/rfid_frac_clkgen.sv
// rfid_frac_clkgen: fractional BLF divider with auxiliary timebase, clean start/stop and period-boundary reload
module rfid_frac_clkgen
  import rfid_clkgen_pkg::*;
#(
  parameter int INT_W  = 10,
  parameter int FRAC_W = 4,
  parameter int AUX_W  = 8
) (
  input  logic              base_clk,
  input  logic              rst_n,
  input  logic              div_en,
  input  logic [INT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic [AUX_W-1:0]  aux_half,
  input  logic              cfg_load,
  output logic              blf_clk,
  output logic              blf_tick,
  output logic              aux_clk,
  output logic              aux_tick,
  output logic              busy,
  output logic              cfg_err
);
  localparam int CW = INT_W + FRAC_W + AUX_W;
  localparam logic [CW-1:0] CFG_RST = {INT_W'(DEF_INT), FRAC_W'(DEF_FRAC), AUX_W'(DEF_AUX)};
  state_e           state_q, state_d;
  logic [INT_W:0]   cnt_q, cnt_d, per_q, per_d, half_q, half_d, per_n, half_n;
  logic [CW-1:0]    sh_q, sh_d, pd_q, pd_d;
  logic [AUX_W-1:0] aux_cnt_q, aux_cnt_d;
  logic pd_v_q, pd_v_d, blf_clk_q, blf_clk_d, blf_tick_q, blf_tick_d;
  logic aux_clk_q, aux_clk_d, aux_tick_q, aux_tick_d, cfg_err_q, cfg_err_d;
  logic active, last, start, stop, wrap;

  // The next period is sized from the shadow config as it will be after this edge
  rfid_frac_accum #(.INT_W(INT_W), .FRAC_W(FRAC_W)) u_accum (
    .base_clk   (base_clk),
    .rst_n      (rst_n),
    .start_i    (start),
    .clear_i    (state_d == IDLE),
    .div_int_i  (sh_d[CW-1 -: INT_W]),
    .div_frac_i (sh_d[AUX_W +: FRAC_W]),
    .per_o      (per_n),
    .half_o     (half_n)
  );

  always_comb begin
    active     = state_q != IDLE;
    last       = active && (cnt_q == per_q - 1'b1);
    start      = div_en && (!active || last);
    stop       = last && !div_en;
    state_d    = start ? RUN : stop ? IDLE : !active ? IDLE : div_en ? RUN : DRAIN;
    cnt_d      = (active && !last) ? cnt_q + 1'b1 : '0;
    pd_d       = cfg_load ? {div_int, div_frac, aux_half} : pd_q;
    pd_v_d     = !last && (pd_v_q || (active && cfg_load));
    sh_d       = (cfg_load && (!active || last)) ? {div_int, div_frac, aux_half} :
                 (last && pd_v_q) ? pd_q : sh_q;
    per_d      = start ? per_n : per_q;
    half_d     = start ? half_n : half_q;
    blf_tick_d = start;
    blf_clk_d  = (state_d != IDLE) && (cnt_d >= half_d);
    wrap       = aux_cnt_q >= sh_q[AUX_W-1:0];
    aux_cnt_d  = (active && !stop && !wrap) ? aux_cnt_q + 1'b1 : '0;
    aux_clk_d  = active && !stop && (aux_clk_q ^ wrap);
    aux_tick_d = active && !stop && wrap;
    cfg_err_d  = sh_d[CW-1 -: INT_W] < INT_W'(MIN_DIV);
  end

  always_ff @(posedge base_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      per_q      <= '0;
      half_q     <= '0;
      sh_q       <= CFG_RST;
      pd_q       <= CFG_RST;
      pd_v_q     <= 1'b0;
      aux_cnt_q  <= '0;
      blf_clk_q  <= 1'b0;
      blf_tick_q <= 1'b0;
      aux_clk_q  <= 1'b0;
      aux_tick_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      per_q      <= per_d;
      half_q     <= half_d;
      sh_q       <= sh_d;
      pd_q       <= pd_d;
      pd_v_q     <= pd_v_d;
      aux_cnt_q  <= aux_cnt_d;
      blf_clk_q  <= blf_clk_d;
      blf_tick_q <= blf_tick_d;
      aux_clk_q  <= aux_clk_d;
      aux_tick_q <= aux_tick_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign blf_clk  = blf_clk_q;
  assign blf_tick = blf_tick_q;
  assign aux_clk  = aux_clk_q;
  assign aux_tick = aux_tick_q;
  assign busy     = active;
  assign cfg_err  = cfg_err_q;
endmodule

// File: tb/tb_rfid_frac_clkgen.sv
// tb_rfid_frac_clkgen: randomized and directed checks of rfid_frac_clkgen against an arithmetic period model
module tb_rfid_frac_clkgen;
  localparam int FR = 16;
  logic       base_clk, rst_n, div_en, cfg_load;
  logic [9:0] div_int;
  logic [3:0] div_frac;
  logic [7:0] aux_half;
  logic       blf_clk, blf_tick, aux_clk, aux_tick, busy, cfg_err;
  int n_tests = 0, n_fail = 0, cyc = 0;
  int tq[$], aq[$], lq[$], hq[$];
  int lo, hi, shape_err;
  bit st;

  rfid_frac_clkgen dut (
    .base_clk (base_clk),
    .rst_n    (rst_n),
    .div_en   (div_en),
    .div_int  (div_int),
    .div_frac (div_frac),
    .aux_half (aux_half),
    .cfg_load (cfg_load),
    .blf_clk  (blf_clk),
    .blf_tick (blf_tick),
    .aux_clk  (aux_clk),
    .aux_tick (aux_tick),
    .busy     (busy),
    .cfg_err  (cfg_err)
  );

  initial begin
    base_clk = 0;
    forever #5 base_clk = ~base_clk;
  end

  initial forever begin
    @(posedge base_clk);
    cyc++;
  end

  // Records tick times and the low/high run lengths of every completed BLF period
  initial forever begin
    @(negedge base_clk);
    if (blf_tick) begin
      if (st) begin
        lq.push_back(lo);
        hq.push_back(hi);
      end
      st = 1; lo = 0; hi = 0;
      tq.push_back(cyc);
    end
    if (aux_tick) aq.push_back(cyc);
    if (busy) begin
      if (blf_clk) hi++;
      else begin
        lo++;
        if (hi != 0) shape_err++;
      end
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Period k of a burst: integer part plus the k-th step of the ideal fraction's staircase
  function automatic int exp_p(input int di, input int df, input int k);
    int e;
    e = (di < 2) ? 2 : di;
    return e + ((k + 1) * df) / FR - (k * df) / FR;
  endfunction

  task automatic step();
    @(posedge base_clk);
    #1;
  endtask

  task automatic load(input int di, input int df, input int ah);
    div_int = 10'(di); div_frac = 4'(df); aux_half = 8'(ah); cfg_load = 1;
    step();
    cfg_load = 0;
  endtask

  task automatic wait_tick(output int t);
    bit ok;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      step();
      ok = blf_tick;
    end
    if (!ok) chk("tick_timeout", 0, 1);
    t = cyc;
  endtask

  task automatic wait_aux(output int t);
    bit ok;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      step();
      ok = aux_tick;
    end
    if (!ok) chk("aux_timeout", 0, 1);
    t = cyc;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && busy; i++) step();
    if (busy) chk("idle_timeout", 0, 1);
  endtask

  task automatic run_burst(input int di, input int df, input int ah, input int nper, input bit do_load);
    int p;
    tq.delete(); aq.delete(); lq.delete(); hq.delete();
    st = 0; shape_err = 0;
    if (do_load) load(di, df, ah);
    div_en = 1;
    for (int i = 0; i < 3000 && tq.size() < nper + 1; i++) step();
    chk("burst_ticks", int'(tq.size() >= nper + 1), 1);
    div_en = 0;
    wait_idle();
    for (int k = 0; k < nper && k + 1 < tq.size() && k < lq.size(); k++) begin
      p = exp_p(di, df, k);
      chk("period", tq[k+1] - tq[k], p);
      chk("low_len", lq[k], p / 2);
      chk("high_len", hq[k], p - p / 2);
    end
    chk("shape", shape_err, 0);
    if (aq.size() > 0 && tq.size() > 0) chk("aux_first", aq[0] - tq[0], ah + 1);
    for (int j = 1; j < aq.size(); j++) chk("aux_int", aq[j] - aq[j-1], ah + 1);
    chk("idle_outs", {blf_clk, aux_clk, busy}, 0);
  endtask

  initial begin
    int t0, t1, t2, t3, t4, t5, t6, ta, tb, nb, drop;
    rst_n = 1; div_en = 0; cfg_load = 0; div_int = 0; div_frac = 0; aux_half = 0;
    #3 rst_n = 0;
    #2 chk("rst_outs", {blf_clk, blf_tick, aux_clk, aux_tick, busy, cfg_err}, 0);
    repeat (2) @(posedge base_clk);
    #1 rst_n = 1;
    step();

    run_burst(2, 0, 0, 4, 0);
    run_burst(8, 0, 0, 8, 1);
    run_burst(5, 8, 0, 16, 1);
    chk("sum_5_8", tq[16] - tq[0], 88);
    run_burst(10, 3, 0, 32, 1);
    chk("sum_10_3_a", tq[16] - tq[0], 163);
    chk("sum_10_3_b", tq[32] - tq[16], 163);

    load(8, 0, 0);
    div_en = 1;
    wait_tick(t0);
    repeat (2) step();
    div_en = 0;
    nb = 0;
    for (int i = 0; i < 50 && busy; i++) begin
      step();
      if (busy) nb++;
    end
    chk("drain_busy", nb, 5);
    chk("drain_clk", blf_clk, 0);

    div_en = 1;
    wait_tick(t0);
    repeat (2) step();
    div_en = 0;
    repeat (2) step();
    div_en = 1;
    drop = 0;
    t1 = 0; t2 = 0;
    for (int i = 0; i < 60 && t2 == 0; i++) begin
      step();
      if (!busy) drop++;
      if (blf_tick) begin
        if (t1 == 0) t1 = cyc;
        else t2 = cyc;
      end
    end
    chk("rerun_p1", t1 - t0, 8);
    chk("rerun_p2", t2 - t1, 8);
    chk("rerun_busy", drop, 0);
    div_en = 0;
    wait_idle();

    load(8, 0, 0);
    div_en = 1;
    wait_tick(t0);
    repeat (2) step();
    load(4, 0, 0);
    wait_tick(t1);
    chk("reload_cur", t1 - t0, 8);
    wait_tick(t2);
    chk("reload_new", t2 - t1, 4);
    repeat (3) step();
    div_int = 6; cfg_load = 1;
    step();
    cfg_load = 0;
    t3 = cyc;
    chk("last_load_tick", blf_tick, 1);
    chk("last_load_cur", t3 - t2, 4);
    wait_tick(t4);
    chk("last_load_new", t4 - t3, 6);
    step();
    div_int = 3; cfg_load = 1; div_en = 0;
    step();
    cfg_load = 0;
    wait_idle();
    div_en = 1;
    wait_tick(t5);
    wait_tick(t6);
    chk("stop_load", t6 - t5, 3);
    div_en = 0;
    wait_idle();

    load(1, 0, 0);
    chk("err_set", cfg_err, 1);
    run_burst(1, 0, 0, 6, 0);
    load(3, 0, 0);
    chk("err_clr", cfg_err, 0);

    load(8, 0, 99);
    div_en = 1;
    wait_tick(t0);
    wait_aux(ta);
    chk("aux_first99", ta - t0, 100);
    chk("aux_clk_hi", aux_clk, 1);
    wait_aux(tb);
    chk("aux_half99", tb - ta, 100);
    chk("aux_clk_lo", aux_clk, 0);
    step();
    rst_n = 0;
    div_en = 0;
    #2 chk("midrun_rst", {blf_clk, blf_tick, aux_clk, aux_tick, busy, cfg_err}, 0);
    step();
    rst_n = 1;
    step();
    run_burst(2, 0, 0, 4, 0);

    for (int r = 0; r < 8; r++) begin
      int di, df, ah, n;
      di = int'($urandom_range(2, 24));
      df = int'($urandom_range(0, 15));
      ah = int'($urandom_range(0, 9));
      n  = int'($urandom_range(6, 20));
      run_burst(di, df, ah, n, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
